// File: rtl/multicycle_ctrl.sv
// Multicycle main controller for the RV32I core. It steps through fetch, decode, execute,
// memory and writeback, and traps on illegal opcodes or on acks that never arrive.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ir,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        br_cond,
  output logic        imem_req,
  output logic        ir_en,
  output logic        pc_en,
  output logic        pc_sel,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic [3:0]  alu_ctl,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_we,
  output logic        wb_sel,
  output logic        trap
);

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpIl    = 7'b0000011;
  localparam logic [6:0] OpS     = 7'b0100011;
  localparam logic [6:0] OpB     = 7'b1100011;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;

  localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    StInit,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StTrap
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              cnt_inc;
  logic              timeout_hit;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              unused_ir;

  assign opcode    = ir[6:0];
  assign funct3    = ir[14:12];
  assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};

  // MEM_TIMEOUT of zero disables the watchdog entirely.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == CntW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_inc   = 1'b0;
    imem_req  = 1'b0;
    ir_en     = 1'b0;
    pc_en     = 1'b0;
    pc_sel    = 1'b0;
    alu_a_sel = 2'd0;
    alu_b_sel = 1'b0;
    alu_ctl   = 4'b0000;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 1'b0;
    trap      = 1'b0;

    unique case (state_q)
      StInit: state_d = StFetch;

      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_en   = 1'b1;
          state_d = StDecode;
        end else if (timeout_hit) begin
          state_d = StTrap;
        end else begin
          cnt_inc = 1'b1;
        end
      end

      StDecode: begin
        unique case (opcode)
          OpR, OpI, OpIl, OpS, OpB, OpLui, OpAuipc: state_d = StExec;
          default:                                  state_d = StTrap;
        endcase
      end

      StExec: begin
        unique case (opcode)
          OpR: begin
            alu_ctl = {ir[30], funct3};
            state_d = StWb;
          end
          OpI: begin
            alu_b_sel = 1'b1;
            // Only the shift-right encoding uses ir[30] to select arithmetic vs logical.
            alu_ctl   = {(funct3 == 3'b101) & ir[30], funct3};
            state_d   = StWb;
          end
          OpIl, OpS: begin
            alu_b_sel = 1'b1;
            state_d   = StMem;
          end
          OpLui: begin
            alu_a_sel = 2'd2;
            alu_b_sel = 1'b1;
            state_d   = StWb;
          end
          OpAuipc: begin
            alu_a_sel = 2'd1;
            alu_b_sel = 1'b1;
            state_d   = StWb;
          end
          OpB: begin
            alu_ctl = {1'b0, funct3};
            pc_en   = 1'b1;
            pc_sel  = br_cond;
            state_d = StFetch;
          end
          default: state_d = StTrap;
        endcase
      end

      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OpS);
        if (dmem_ack) begin
          if (opcode == OpS) begin
            pc_en   = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end else if (timeout_hit) begin
          state_d = StTrap;
        end else begin
          cnt_inc = 1'b1;
        end
      end

      StWb: begin
        reg_we  = 1'b1;
        wb_sel  = (opcode == OpIl);
        pc_en   = 1'b1;
        state_d = StFetch;
      end

      StTrap: trap = 1'b1;

      default: state_d = StTrap;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_inc) begin
      cnt_d = cnt_q + CntW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks instruction classes cycle by cycle and checks
// every control output against hand-computed vectors.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ir;
  logic        imem_ack, dmem_ack, br_cond;
  logic        imem_req, ir_en, pc_en, pc_sel;
  logic [1:0]  alu_a_sel;
  logic        alu_b_sel;
  logic [3:0]  alu_ctl;
  logic        dmem_req, dmem_we, reg_we, wb_sel, trap;
  logic [15:0] outs;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ir       (ir),
    .imem_ack (imem_ack),
    .dmem_ack (dmem_ack),
    .br_cond  (br_cond),
    .imem_req (imem_req),
    .ir_en    (ir_en),
    .pc_en    (pc_en),
    .pc_sel   (pc_sel),
    .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel),
    .alu_ctl  (alu_ctl),
    .dmem_req (dmem_req),
    .dmem_we  (dmem_we),
    .reg_we   (reg_we),
    .wb_sel   (wb_sel),
    .trap     (trap)
  );

  always #5 clk = ~clk;

  assign outs = {imem_req, ir_en, pc_en, pc_sel, alu_a_sel, alu_b_sel, alu_ctl,
                 dmem_req, dmem_we, reg_we, wb_sel, trap};

  // Packs an expected output vector in the same order as outs.
  function automatic logic [15:0] o(input logic ireq, input logic ien, input logic pen,
                                    input logic psel, input logic [1:0] a, input logic b,
                                    input logic [3:0] ctl, input logic dreq, input logic dwe,
                                    input logic rwe, input logic wbs, input logic tr);
    return {ireq, ien, pen, psel, a, b, ctl, dreq, dwe, rwe, wbs, tr};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses reset, checks the reset and INIT outputs, and leaves the DUT in FETCH.
  task automatic do_reset(input string tag);
    #1 rst_n = 1'b0;
    #1 chk({tag, "_rst"}, outs, 16'h0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk({tag, "_init"}, outs, 16'h0000);
    tick();
  endtask

  // Runs a FETCH/DECODE/EXEC/WB instruction with zero-wait acks; ends in FETCH.
  task automatic run_wb(input string tag, input logic [31:0] irv, input logic [15:0] exec_exp);
    ir       = irv;
    imem_ack = 1'b1;
    chk({tag, "_fetch"}, outs, o(1, 1, 0, 0, 2'd0, 0, 4'h0, 0, 0, 0, 0, 0));
    tick();
    chk({tag, "_decode"}, outs, 16'h0000);
    tick();
    chk({tag, "_exec"}, outs, exec_exp);
    tick();
    chk({tag, "_wb"}, outs, o(0, 0, 1, 0, 2'd0, 0, 4'h0, 0, 0, 1, 0, 0));
    tick();
  endtask

  initial begin
    rst_n    = 1'b0;
    ir       = 32'h0000_0000;
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    br_cond  = 1'b0;
    do_reset("start");

    // R/I/U types: four cycles, result lands in cycle 4.
    run_wb("add",   32'h002081B3, o(0, 0, 0, 0, 2'd0, 0, 4'b0000, 0, 0, 0, 0, 0));
    run_wb("sub",   32'h402081B3, o(0, 0, 0, 0, 2'd0, 0, 4'b1000, 0, 0, 0, 0, 0));
    run_wb("srai",  32'h4030D093, o(0, 0, 0, 0, 2'd0, 1, 4'b1101, 0, 0, 0, 0, 0));
    run_wb("srli",  32'h0030D093, o(0, 0, 0, 0, 2'd0, 1, 4'b0101, 0, 0, 0, 0, 0));
    run_wb("addi",  32'h40008093, o(0, 0, 0, 0, 2'd0, 1, 4'b0000, 0, 0, 0, 0, 0));
    run_wb("lui",   32'h123450B7, o(0, 0, 0, 0, 2'd2, 1, 4'b0000, 0, 0, 0, 0, 0));
    run_wb("auipc", 32'h00001097, o(0, 0, 0, 0, 2'd1, 1, 4'b0000, 0, 0, 0, 0, 0));

    // LW with dmem_ack delayed three cycles.
    ir       = 32'h0080A283;
    dmem_ack = 1'b0;
    chk("lw_fetch", outs, o(1, 1, 0, 0, 2'd0, 0, 4'h0, 0, 0, 0, 0, 0));
    tick();
    chk("lw_decode", outs, 16'h0000);
    tick();
    chk("lw_exec", outs, o(0, 0, 0, 0, 2'd0, 1, 4'h0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("lw_mem_wait%0d", i), outs, o(0, 0, 0, 0, 2'd0, 0, 4'h0, 1, 0, 0, 0, 0));
    end
    tick();
    dmem_ack = 1'b1;
    chk("lw_mem_ack", outs, o(0, 0, 0, 0, 2'd0, 0, 4'h0, 1, 0, 0, 0, 0));
    tick();
    chk("lw_wb", outs, o(0, 0, 1, 0, 2'd0, 0, 4'h0, 0, 0, 1, 1, 0));
    tick();

    // SW x2,4(x1): four cycles, PC advances on the ack.
    ir = 32'h0020A223;
    chk("sw_fetch", outs, o(1, 1, 0, 0, 2'd0, 0, 4'h0, 0, 0, 0, 0, 0));
    tick();
    chk("sw_decode", outs, 16'h0000);
    tick();
    chk("sw_exec", outs, o(0, 0, 0, 0, 2'd0, 1, 4'h0, 0, 0, 0, 0, 0));
    tick();
    chk("sw_mem", outs, o(0, 0, 1, 0, 2'd0, 0, 4'h0, 1, 1, 0, 0, 0));
    tick();

    // BEQ taken then not taken: three cycles, no register write.
    for (int t = 1; t >= 0; t--) begin
      ir      = 32'h00208463;
      br_cond = t[0];
      chk($sformatf("beq%0d_fetch", t), outs, o(1, 1, 0, 0, 2'd0, 0, 4'h0, 0, 0, 0, 0, 0));
      tick();
      chk($sformatf("beq%0d_decode", t), outs, 16'h0000);
      tick();
      chk($sformatf("beq%0d_exec", t), outs,
          o(0, 0, 1, t[0], 2'd0, 0, 4'b0000, 0, 0, 0, 0, 0));
      tick();
    end
    // BNE funct3 passes through to alu_ctl.
    ir      = 32'h00209463;
    br_cond = 1'b1;
    tick();
    tick();
    chk("bne_exec", outs, o(0, 0, 1, 1, 2'd0, 0, 4'b0001, 0, 0, 0, 0, 0));
    tick();
    chk("bne_back_fetch", outs, o(1, 1, 0, 0, 2'd0, 0, 4'h0, 0, 0, 0, 0, 0));

    // Illegal opcode traps and stays trapped despite acks.
    ir = 32'hFFFFFFFF;
    tick();
    chk("ill_decode", outs, 16'h0000);
    tick();
    chk("ill_trap", outs, 16'h0001);
    repeat (5) tick();
    chk("ill_trap_sticky", outs, 16'h0001);
    do_reset("ill");
    chk("ill_refetch", outs, o(1, 0, 0, 0, 2'd0, 0, 4'h0, 0, 0, 0, 0, 0) | 16'h4000);

    // imem_ack low for 16 cycles traps on the watchdog.
    imem_ack = 1'b0;
    #1 chk("to_fetch1", outs, o(1, 0, 0, 0, 2'd0, 0, 4'h0, 0, 0, 0, 0, 0));
    repeat (15) tick();
    chk("to_fetch16", outs, o(1, 0, 0, 0, 2'd0, 0, 4'h0, 0, 0, 0, 0, 0));
    tick();
    chk("to_trap", outs, 16'h0001);
    imem_ack = 1'b1;
    repeat (3) tick();
    chk("to_trap_sticky", outs, 16'h0001);
    do_reset("to");

    // Reset asserted mid-MEM withdraws dmem_req immediately.
    ir       = 32'h0080A283;
    dmem_ack = 1'b0;
    tick();
    tick();
    tick();
    chk("rm_mem", outs, o(0, 0, 0, 0, 2'd0, 0, 4'h0, 1, 0, 0, 0, 0));
    #2 rst_n = 1'b0;
    #1 chk("rm_async", outs, 16'h0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rm_init", outs, 16'h0000);
    tick();
    chk("rm_fetch", outs, o(1, 1, 0, 0, 2'd0, 0, 4'h0, 0, 0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net against a hung sequence.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
